twiddle_gen: RTL and testbench

Pipelined twiddle-factor generator for the radix-2 FFT datapath, replacing the per-stage combinational twiddle ROMs. A single quarter-wave cosine table plus quadrant folding serves every stage. The stage number is a run-time input, and the block supports forward and inverse (conjugate) modes. A valid/ready handshake sits on both sides, so it plugs directly into the butterfly scheduler pipeline.

---
 rtl/fft_pkg.sv | 25 ++
 rtl/twiddle_quarter_rom.sv | 35 +++
 rtl/twiddle_gen.sv | 138 +++++++++++++
 tb/tb_twiddle_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, twiddle pair type and
// the quarter-wave cosine table entry function.
package fft_pkg;

   localparam int FFT_N_DEF = 1024;
   localparam int LOG2N_DEF = $clog2(FFT_N_DEF);
   localparam int TW_W_DEF  = 16;
   localparam int TW_AMP    = 2**(TW_W_DEF-1) - 1;
   localparam real TW_PI    = 3.14159265358979323846;

   typedef struct packed {
      logic signed [TW_W_DEF-1:0] re;
      logic signed [TW_W_DEF-1:0] im;
   } tw_pair_t;

   // round(A*cos(2*pi*i/n)), ties away from zero
   function automatic int tw_quarter(int i, int n, int w);
      real amp;
      real ang;
      amp = real'((1 << (w-1)) - 1);
      ang = 2.0 * TW_PI * real'(i) / real'(n);
      return int'(amp * $cos(ang));
   endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Quarter-wave cosine table, N/4+1 entries,
// synchronous read with hold when not enabled.
module twiddle_quarter_rom
   import fft_pkg::*;
#(
   parameter int FFT_N = FFT_N_DEF,
   parameter int TW_W  = TW_W_DEF,
   parameter int AW    = $clog2(FFT_N/4+1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   output logic [TW_W-1:0] q
);

   localparam int DEPTH = FFT_N/4 + 1;

   logic [TW_W-1:0] mem [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_tab
      localparam int CV = tw_quarter(i, FFT_N, TW_W);
      assign mem[i] = TW_W'(CV);
   end

   // registered read; holds while the pipeline stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= mem[addr];
      end
   end

endmodule

// File: rtl/twiddle_gen.sv
// Two-stage twiddle generator: quadrant fold in S1,
// table read and sign application in S2.
module twiddle_gen
   import fft_pkg::*;
#(
   parameter int FFT_N = FFT_N_DEF,
   parameter int TW_W  = TW_W_DEF,
   parameter int LOG2N = $clog2(FFT_N)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [LOG2N-2:0]           in_idx,
   input  logic [$clog2(LOG2N)-1:0]   in_stage,
   input  logic                       in_inv,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [TW_W-1:0]     out_re,
   output logic signed [TW_W-1:0]     out_im
);

   localparam int HALF = FFT_N / 2;
   localparam int QTR  = FFT_N / 4;
   localparam int KW   = LOG2N - 1;
   localparam int AW   = $clog2(QTR + 1);

   logic [1:0]      rst_sync;
   logic            rst_in_n;
   logic            stall;
   logic            adv;
   logic            fire;
   logic [KW-1:0]   k;
   int              kq;
   logic [AW-1:0]   c_addr;
   logic [AW-1:0]   s_addr;
   logic            c_neg;
   logic            s1_valid;
   logic [AW-1:0]   s1_caddr;
   logic [AW-1:0]   s1_saddr;
   logic            s1_cneg;
   logic            s1_sneg;
   logic            s2_cneg;
   logic            s2_sneg;
   logic [TW_W-1:0] rom_c;
   logic [TW_W-1:0] rom_s;

   // async assert, clock-aligned release of the internal reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= '0;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_in_n = rst_sync[1];
   assign stall    = out_valid && !out_ready;
   assign adv      = !stall;
   assign in_ready = adv && rst_in_n;
   assign fire     = in_valid && in_ready;

   // twiddle index and quadrant fold into table addresses
   always_comb begin
      k      = in_idx << in_stage;
      if (int'(in_stage) >= LOG2N) begin
         k = '0;
      end
      kq     = int'(k);
      c_addr = AW'(kq);
      s_addr = AW'(QTR - kq);
      c_neg  = 1'b0;
      if (kq > QTR) begin
         c_addr = AW'(HALF - kq);
         s_addr = AW'(kq - QTR);
         c_neg  = 1'b1;
      end
   end

   // S1 register: addresses and sign flags
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         s1_valid <= 1'b0;
         s1_caddr <= '0;
         s1_saddr <= '0;
         s1_cneg  <= 1'b0;
         s1_sneg  <= 1'b0;
      end else if (adv) begin
         s1_valid <= fire;
         s1_caddr <= c_addr;
         s1_saddr <= s_addr;
         s1_cneg  <= c_neg;
         s1_sneg  <= !in_inv;
      end
   end

   // S2 register: valid and signs aligned with table data
   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         out_valid <= 1'b0;
         s2_cneg   <= 1'b0;
         s2_sneg   <= 1'b0;
      end else if (adv) begin
         out_valid <= s1_valid;
         s2_cneg   <= s1_cneg;
         s2_sneg   <= s1_sneg;
      end
   end

   twiddle_quarter_rom #(
      .FFT_N (FFT_N),
      .TW_W  (TW_W),
      .AW    (AW)
   ) u_rom_cos (
      .clk   (clk),
      .rst_n (rst_in_n),
      .en    (adv),
      .addr  (s1_caddr),
      .q     (rom_c)
   );

   twiddle_quarter_rom #(
      .FFT_N (FFT_N),
      .TW_W  (TW_W),
      .AW    (AW)
   ) u_rom_sin (
      .clk   (clk),
      .rst_n (rst_in_n),
      .en    (adv),
      .addr  (s1_saddr),
      .q     (rom_s)
   );

   // table magnitudes never exceed A; negating zero stays zero
   assign out_re = s2_cneg ? -rom_c : rom_c;
   assign out_im = s2_sneg ? -rom_s : rom_s;

endmodule

// File: tb/tb_twiddle_gen.sv
// Directed and streaming checks for twiddle_gen
// against an independent cos/sin reference.
module tb_twiddle_gen;
   import fft_pkg::*;

   localparam int N  = 1024;
   localparam int W  = 16;
   localparam int LG = 10;
   localparam int SW = 4;
   localparam real PI = 3.141592653589793;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [LG-2:0]       in_idx = '0;
   logic [SW-1:0]       in_stage = '0;
   logic                in_inv = 1'b0;
   logic                out_valid;
   logic                out_ready = 1'b0;
   logic signed [W-1:0] out_re;
   logic signed [W-1:0] out_im;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   twiddle_gen #(
      .FFT_N (N),
      .TW_W  (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .in_stage  (in_stage),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_re    (out_re),
      .out_im    (out_im)
   );

   task automatic chk(string tag, logic signed [31:0] got,
                      logic signed [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic tw_pair_t gold(int idx, int stage, bit inv);
      int k;
      int c;
      int s;
      real ang;
      tw_pair_t p;
      k = (stage >= LG) ? 0 : ((idx << stage) % (N/2));
      ang = 2.0 * PI * real'(k) / real'(N);
      c = int'(real'(TW_AMP) * $cos(ang));
      s = int'(real'(TW_AMP) * $sin(ang));
      p.re = W'(c);
      p.im = inv ? W'(s) : W'(-s);
      return p;
   endfunction

   task automatic do_req(string tag, bit inv, int stage, int idx,
                         int ere, int eim);
      int lat;
      @(negedge clk);
      in_valid  = 1'b1;
      in_inv    = inv;
      in_stage  = SW'(stage);
      in_idx    = (LG-1)'(idx);
      out_ready = 1'b1;
      #1 chk({tag, "_rdy"}, 32'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 2);
      chk({tag, "_re"}, 32'(out_re), ere);
      chk({tag, "_im"}, 32'(out_im), eim);
   endtask

   task automatic run_stream(string tag, int count, int rdy_pct,
                             bit rnd_cfg);
      tw_pair_t q[$];
      tw_pair_t e;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int run = 0;
      int maxrun = 0;
      int bad_rdy = 0;
      int bad_hold = 0;
      int bad_val = 0;
      int st;
      bit iv;
      bit hold = 1'b0;
      logic signed [W-1:0] hre = '0;
      logic signed [W-1:0] him = '0;
      while (got < count && cyc < count * 8 + 50) begin
         @(negedge clk);
         if (hold && (!out_valid || out_re !== hre || out_im !== him))
            bad_hold++;
         st = rnd_cfg ? $urandom_range(11) : 0;
         iv = rnd_cfg ? 1'($urandom_range(1)) : 1'b0;
         in_valid  = (sent < count);
         in_idx    = (LG-1)'(sent);
         in_stage  = SW'(st);
         in_inv    = iv;
         out_ready = ($urandom_range(99) < rdy_pct);
         #1;
         if (in_ready !== !(out_valid && !out_ready)) bad_rdy++;
         hold = out_valid && !out_ready;
         hre  = out_re;
         him  = out_im;
         run  = out_valid ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
         if (in_valid && in_ready) begin
            q.push_back(gold(sent, st, iv));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               bad_val++;
            end else begin
               e = q.pop_front();
               if (out_re !== e.re || out_im !== e.im) begin
                  bad_val++;
                  if (bad_val < 4)
                     $display("FAIL %s_val: got %0d,%0d expected %0d,%0d",
                              tag, out_re, out_im, e.re, e.im);
               end
            end
            got++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      chk({tag, "_count"}, got, count);
      chk({tag, "_values"}, bad_val, 0);
      chk({tag, "_inready"}, bad_rdy, 0);
      chk({tag, "_hold"}, bad_hold, 0);
      chk({tag, "_left"}, q.size(), 0);
      if (rdy_pct >= 100) chk({tag, "_contig"}, maxrun, count);
      @(negedge clk);
      chk({tag, "_drain"}, 32'(out_valid), 0);
   endtask

   initial begin
      int stale;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_re", 32'(out_re), 0);
      chk("rst_im", 32'(out_im), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_inready", 32'(in_ready), 1);

      do_req("f_s0_j0",   1'b0, 0, 0,   32767,  0);
      do_req("f_s0_j128", 1'b0, 0, 128, 23170,  -23170);
      do_req("f_s0_j256", 1'b0, 0, 256, 0,      -32767);
      do_req("f_s0_j384", 1'b0, 0, 384, -23170, -23170);
      do_req("f_s0_j511", 1'b0, 0, 511, -32766, -201);
      do_req("i_s0_j256", 1'b1, 0, 256, 0,      32767);
      do_req("i_s1_j128", 1'b1, 1, 128, 0,      32767);
      do_req("f_s2_j200", 1'b0, 2, 200, -6393,  -32137);
      do_req("f_s12",     1'b0, 12, 5,  32767,  0);
      do_req("i_s15",     1'b1, 15, 511, 32767, 0);

      run_stream("full", 512, 100, 1'b0);
      run_stream("bp",   300, 50,  1'b1);

      @(negedge clk);
      in_valid  = 1'b1;
      in_idx    = '0;
      in_stage  = '0;
      in_inv    = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      in_idx = (LG-1)'(128);
      @(negedge clk);
      in_valid = 1'b0;
      chk("fl_pre_valid", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk("fl_valid", 32'(out_valid), 0);
      chk("fl_re", 32'(out_re), 0);
      chk("fl_im", 32'(out_im), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      chk("fl_stale", stale, 0);
      chk("fl_inready", 32'(in_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
